enet_rgmii_to_gmii_rx: RTL and testbench

- Receive-side RGMII-to-GMII bridge for the Ethernet MAC path; it is the counterpart of the transmit-side GMII-to-RGMII DDR bridge.
- Captures 4-bit DDR RXD/RX_CTL on both edges of rgmii_rxc and rebuilds the 8-bit GMII byte stream with DV/ER.
- Supports 10/100 nibble mode.
- Also decodes RGMII in-band link status, tracks frame boundaries (preamble/SFD/length), and keeps frame and error statistics for the MAC receive logic.

---
 rtl/enet_rgmii_to_gmii_rx.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_enet_rgmii_to_gmii_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enet_rgmii_to_gmii_rx.sv
// RGMII receive DDR capture rebuilt into a GMII byte stream, with
// in-band link status, frame boundary tracking and rx statistics.
module enet_rgmii_to_gmii_rx #(
  parameter int STATUS_FILT = 4,
  parameter int LEN_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             rgmii_rxc,
  input  logic             rst_n,
  input  logic [3:0]       rgmii_rxd,
  input  logic             rgmii_rx_ctl,
  input  logic             cfg_gbit,
  output logic             gmii_rx_valid,
  output logic [7:0]       gmii_rxd,
  output logic             gmii_rx_dv,
  output logic             gmii_rx_er,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             link_fdx,
  output logic             frame_start,
  output logic             frame_end,
  output logic             frame_bad,
  output logic [LEN_W-1:0] frame_len,
  output logic             false_carrier,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_e;

  localparam logic [3:0] FILT = 4'(STATUS_FILT);

  logic [3:0] rxd_r_q, rxd_f_q;
  logic       ctl_r_q, ctl_f_q;
  logic       c_dv, c_er;

  logic       valid_q, valid_d;
  logic [7:0] rxd_q, rxd_d;
  logic       dv_q, dv_d, er_q, er_d;
  logic       dangle_q, dangle_d;
  logic       phase_q, phase_d;
  logic [3:0] lo_q, lo_d;
  logic       er_acc_q, er_acc_d;
  logic       idle_tog_q, idle_tog_d;

  logic [3:0] st_prev_q, st_prev_d;
  logic [3:0] st_cnt_q, st_cnt_d;
  logic       link_up_q, link_up_d;
  logic [1:0] speed_q, speed_d;
  logic       fdx_q, fdx_d;

  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic       end_q, end_d;
  logic       fbad_q, fbad_d;
  logic       flag_q, flag_d;
  logic       fc_q, fc_d;
  logic       err_inc;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

  always_ff @(posedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n) begin
      rxd_r_q <= '0;
      ctl_r_q <= 1'b0;
    end else begin
      rxd_r_q <= rgmii_rxd;
      ctl_r_q <= rgmii_rx_ctl;
    end
  end

  always_ff @(negedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n) begin
      rxd_f_q <= '0;
      ctl_f_q <= 1'b0;
    end else begin
      rxd_f_q <= rgmii_rxd;
      ctl_f_q <= rgmii_rx_ctl;
    end
  end

  assign c_dv = ctl_r_q;
  assign c_er = ctl_r_q ^ ctl_f_q;

  // Byte rebuild; nibble mode pairs rising nibbles low-half first
  always_comb begin
    valid_d    = 1'b0;
    rxd_d      = rxd_q;
    dv_d       = dv_q;
    er_d       = er_q;
    dangle_d   = 1'b0;
    phase_d    = phase_q;
    lo_d       = lo_q;
    er_acc_d   = er_acc_q;
    idle_tog_d = idle_tog_q;
    if (cfg_gbit) begin
      valid_d    = 1'b1;
      rxd_d      = {rxd_f_q, rxd_r_q};
      dv_d       = c_dv;
      er_d       = c_er;
      phase_d    = 1'b0;
      idle_tog_d = 1'b0;
    end else if (c_dv) begin
      idle_tog_d = 1'b1;
      if (!phase_q) begin
        phase_d  = 1'b1;
        lo_d     = rxd_r_q;
        er_acc_d = c_er;
      end else begin
        phase_d = 1'b0;
        valid_d = 1'b1;
        rxd_d   = {rxd_r_q, lo_q};
        dv_d    = 1'b1;
        er_d    = er_acc_q | c_er;
      end
    end else begin
      phase_d    = 1'b0;
      idle_tog_d = ~idle_tog_q;
      valid_d    = idle_tog_q;
      dangle_d   = phase_q;
      if (idle_tog_q) begin
        rxd_d = {4'h0, rxd_r_q};
        dv_d  = 1'b0;
        er_d  = c_er;
      end
    end
  end

  always_comb begin
    st_prev_d = st_prev_q;
    st_cnt_d  = st_cnt_q;
    link_up_d = link_up_q;
    speed_d   = speed_q;
    fdx_d     = fdx_q;
    if (!c_dv && !c_er) begin
      if (rxd_r_q[2:1] == 2'b11) begin
        st_cnt_d = 4'd0;
      end else begin
        st_prev_d = rxd_r_q;
        if (rxd_r_q != st_prev_q)
          st_cnt_d = 4'd1;
        else if (st_cnt_q < FILT)
          st_cnt_d = st_cnt_q + 4'd1;
        if (st_cnt_d == FILT) begin
          link_up_d = rxd_r_q[0];
          speed_d   = rxd_r_q[2:1];
          fdx_d     = rxd_r_q[3];
        end
      end
    end
  end

  always_ff @(posedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (valid_q) begin
      unique case (state_q)
        IDLE: begin
          if (dv_q) begin
            if (rxd_q == 8'h55)
              state_d = PRE;
            else if (rxd_q == 8'hD5)
              state_d = DATA;
            else
              state_d = DROP;
          end
        end
        PRE: begin
          if (!dv_q)
            state_d = IDLE;
          else if (rxd_q == 8'hD5)
            state_d = DATA;
          else if (rxd_q != 8'h55)
            state_d = DROP;
        end
        DATA, DROP: begin
          if (!dv_q)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    start_d = 1'b0;
    end_d   = 1'b0;
    fbad_d  = 1'b0;
    fc_d    = 1'b0;
    err_inc = 1'b0;
    len_d   = len_q;
    flag_d  = flag_q;
    fcnt_d  = fcnt_q;
    if (valid_q) begin
      if (!dv_q && er_q && rxd_q == 8'h0E) begin
        fc_d    = 1'b1;
        err_inc = 1'b1;
      end
      unique case (state_q)
        IDLE, PRE: begin
          if (dv_q && rxd_q == 8'hD5) begin
            start_d = 1'b1;
            len_d   = '0;
            flag_d  = 1'b0;
          end
        end
        DATA: begin
          if (dv_q) begin
            if (len_q != {LEN_W{1'b1}})
              len_d = len_q + LEN_W'(1);
            if (er_q)
              flag_d = 1'b1;
          end else begin
            end_d   = 1'b1;
            fbad_d  = flag_q | dangle_q;
            fcnt_d  = fcnt_q + CNT_W'(1);
            err_inc = err_inc | flag_q | dangle_q;
          end
        end
        default: ;
      endcase
    end
    ecnt_d = ecnt_q + CNT_W'(err_inc);
  end

  always_ff @(posedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rxd_q      <= '0;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      dangle_q   <= 1'b0;
      phase_q    <= 1'b0;
      lo_q       <= '0;
      er_acc_q   <= 1'b0;
      idle_tog_q <= 1'b0;
      st_prev_q  <= '0;
      st_cnt_q   <= '0;
      link_up_q  <= 1'b0;
      speed_q    <= '0;
      fdx_q      <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      fbad_q     <= 1'b0;
      flag_q     <= 1'b0;
      fc_q       <= 1'b0;
      len_q      <= '0;
      fcnt_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      rxd_q      <= rxd_d;
      dv_q       <= dv_d;
      er_q       <= er_d;
      dangle_q   <= dangle_d;
      phase_q    <= phase_d;
      lo_q       <= lo_d;
      er_acc_q   <= er_acc_d;
      idle_tog_q <= idle_tog_d;
      st_prev_q  <= st_prev_d;
      st_cnt_q   <= st_cnt_d;
      link_up_q  <= link_up_d;
      speed_q    <= speed_d;
      fdx_q      <= fdx_d;
      start_q    <= start_d;
      end_q      <= end_d;
      fbad_q     <= fbad_d;
      flag_q     <= flag_d;
      fc_q       <= fc_d;
      len_q      <= len_d;
      fcnt_q     <= fcnt_d;
      ecnt_q     <= ecnt_d;
    end
  end

  assign gmii_rx_valid = valid_q;
  assign gmii_rxd      = rxd_q;
  assign gmii_rx_dv    = dv_q;
  assign gmii_rx_er    = er_q;
  assign link_up       = link_up_q;
  assign link_speed    = speed_q;
  assign link_fdx      = fdx_q;
  assign frame_start   = start_q;
  assign frame_end     = end_q;
  assign frame_bad     = fbad_q;
  assign frame_len     = len_q;
  assign false_carrier = fc_q;
  assign frame_cnt     = fcnt_q;
  assign err_cnt       = ecnt_q;

endmodule

// File: tb/tb_enet_rgmii_to_gmii_rx.sv
// Scoreboard bench for enet_rgmii_to_gmii_rx: directed DDR frames,
// status, false-carrier and reset cases.
module tb_enet_rgmii_to_gmii_rx;

  logic        rgmii_rxc = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rgmii_rxd = '0;
  logic        rgmii_rx_ctl = 1'b0;
  logic        cfg_gbit = 1'b1;
  logic        gmii_rx_valid;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic        link_up;
  logic [1:0]  link_speed;
  logic        link_fdx;
  logic        frame_start;
  logic        frame_end;
  logic        frame_bad;
  logic [15:0] frame_len;
  logic        false_carrier;
  logic [31:0] frame_cnt;
  logic [31:0] err_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int starts = 0;
  int ends = 0;
  int fcs = 0;

  logic [8:0]  exp_q[$];
  logic [16:0] fe_q[$];

  always #4 rgmii_rxc = ~rgmii_rxc;

  enet_rgmii_to_gmii_rx dut (
    .rgmii_rxc     (rgmii_rxc),
    .rst_n         (rst_n),
    .rgmii_rxd     (rgmii_rxd),
    .rgmii_rx_ctl  (rgmii_rx_ctl),
    .cfg_gbit      (cfg_gbit),
    .gmii_rx_valid (gmii_rx_valid),
    .gmii_rxd      (gmii_rxd),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rx_er    (gmii_rx_er),
    .link_up       (link_up),
    .link_speed    (link_speed),
    .link_fdx      (link_fdx),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .frame_bad     (frame_bad),
    .frame_len     (frame_len),
    .false_carrier (false_carrier),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ddr(input logic [3:0] r, input logic cr,
                     input logic [3:0] f, input logic cf);
    @(negedge rgmii_rxc);
    #1;
    rgmii_rxd = r;
    rgmii_rx_ctl = cr;
    @(posedge rgmii_rxc);
    #1;
    rgmii_rxd = f;
    rgmii_rx_ctl = cf;
  endtask

  task automatic gbyte(input logic [7:0] b, input logic dv, input logic er);
    ddr(b[3:0], dv, b[7:4], dv ^ er);
    if (dv)
      exp_q.push_back({er, b});
  endtask

  task automatic gidle(input int n);
    for (int i = 0; i < n; i++)
      gbyte(8'h00, 1'b0, 1'b0);
  endtask

  task automatic nib(input logic [3:0] n, input logic dv);
    ddr(n, dv, n, dv);
  endtask

  task automatic mii_frame(input int ndata);
    logic [3:0] lo;
    lo = '0;
    for (int i = 0; i < 7; i++) begin
      nib(4'h5, 1'b1);
      nib(4'h5, 1'b1);
      exp_q.push_back(9'h055);
    end
    nib(4'h5, 1'b1);
    nib(4'hD, 1'b1);
    exp_q.push_back(9'h0D5);
    for (int k = 0; k < ndata; k++) begin
      nib(4'(k + 3), 1'b1);
      if (k % 2 == 0)
        lo = 4'(k + 3);
      else
        exp_q.push_back({1'b0, 4'(k + 3), lo});
    end
    for (int i = 0; i < 8; i++)
      nib(4'h0, 1'b0);
  endtask

  always @(negedge rgmii_rxc) begin
    if (rst_n) begin
      if (gmii_rx_valid && gmii_rx_dv) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL byte_unexpected: got %0h expected none", gmii_rxd);
        end else begin
          chk("byte", {gmii_rx_er, gmii_rxd}, exp_q.pop_front());
        end
      end
      if (frame_start)
        starts++;
      if (false_carrier)
        fcs++;
      if (frame_end) begin
        ends++;
        if (fe_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL frame_end_unexpected: got len %0d expected none",
                   frame_len);
        end else begin
          chk("frame_end", {frame_bad, frame_len}, fe_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge rgmii_rxc);
    #1;
    chk("reset_state",
        {gmii_rx_valid, gmii_rxd, gmii_rx_dv, gmii_rx_er, link_up,
         link_speed, link_fdx, frame_start, frame_end, frame_bad,
         frame_len, false_carrier, frame_cnt, err_cnt}, '0);
    @(negedge rgmii_rxc);
    rst_n = 1'b1;
    gidle(4);

    // 1000 mode good frame
    for (int i = 0; i < 7; i++) begin
      gbyte(8'h55, 1'b1, 1'b0);
      if (i == 0)
        chk("latency_before", gmii_rx_dv, 1'b0);
      if (i == 1)
        chk("latency_first", {gmii_rx_dv, gmii_rxd}, {1'b1, 8'h55});
    end
    gbyte(8'hD5, 1'b1, 1'b0);
    fe_q.push_back({1'b0, 16'd64});
    for (int i = 0; i < 64; i++)
      gbyte(8'(i), 1'b1, 1'b0);
    gidle(6);
    chk("g1_starts", starts, 1);
    chk("g1_frame_cnt", frame_cnt, 32'd1);
    chk("g1_err_cnt", err_cnt, 32'd0);
    chk("g1_len_hold", frame_len, 16'd64);

    // 1000 mode frame with ER on data byte 10
    for (int i = 0; i < 7; i++)
      gbyte(8'h55, 1'b1, 1'b0);
    gbyte(8'hD5, 1'b1, 1'b0);
    fe_q.push_back({1'b1, 16'd64});
    for (int i = 0; i < 64; i++)
      gbyte(8'(i), 1'b1, i == 10);
    gidle(6);
    chk("g2_frame_cnt", frame_cnt, 32'd2);
    chk("g2_err_cnt", err_cnt, 32'd1);

    // false carrier, then carrier extend
    gbyte(8'h0E, 1'b0, 1'b1);
    gidle(4);
    chk("fc_pulses", fcs, 1);
    chk("fc_err_cnt", err_cnt, 32'd2);
    gbyte(8'h0F, 1'b0, 1'b1);
    gidle(4);
    chk("ext_pulses", fcs, 1);
    chk("ext_err_cnt", err_cnt, 32'd2);

    // bad first byte -> dropped frame
    gbyte(8'h12, 1'b1, 1'b0);
    gbyte(8'h55, 1'b1, 1'b0);
    gbyte(8'hD5, 1'b1, 1'b0);
    gbyte(8'h01, 1'b1, 1'b0);
    gidle(6);
    chk("drop_starts", starts, 2);
    chk("drop_ends", ends, 2);
    chk("drop_cnts", {frame_cnt, err_cnt}, {32'd2, 32'd2});

    // 10/100 nibble mode, even and odd data nibbles
    cfg_gbit = 1'b0;
    for (int i = 0; i < 4; i++)
      nib(4'h0, 1'b0);
    fe_q.push_back({1'b0, 16'd10});
    mii_frame(20);
    chk("mii_starts", starts, 3);
    chk("mii_frame_cnt", frame_cnt, 32'd3);
    chk("mii_len", frame_len, 16'd10);
    fe_q.push_back({1'b1, 16'd10});
    mii_frame(21);
    chk("mii_odd_cnts", {frame_cnt, err_cnt}, {32'd4, 32'd3});
    chk("scoreboard_empty", {exp_q.size(), fe_q.size()}, '0);

    // in-band status filter
    cfg_gbit = 1'b1;
    chk("link_before", {link_up, link_speed, link_fdx}, 4'b0000);
    for (int i = 0; i < 3; i++)
      ddr(4'b1101, 1'b0, 4'b1101, 1'b0);
    for (int i = 0; i < 3; i++)
      ddr(4'b1011, 1'b0, 4'b1011, 1'b0);
    chk("link_no_update", {link_up, link_speed, link_fdx}, 4'b0000);
    ddr(4'b1011, 1'b0, 4'b1011, 1'b0);
    chk("link_three_stable", {link_up, link_speed, link_fdx}, 4'b0000);
    @(posedge rgmii_rxc);
    #1;
    chk("link_update", {link_up, link_speed, link_fdx}, 4'b1011);

    // reset mid-frame
    for (int i = 0; i < 3; i++)
      gbyte(8'h55, 1'b1, 1'b0);
    gbyte(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      gbyte(8'hA0 + 8'(i), 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_frame",
        {gmii_rx_valid, gmii_rxd, gmii_rx_dv, gmii_rx_er, link_up,
         link_speed, link_fdx, frame_start, frame_end, frame_bad,
         frame_len, false_carrier, frame_cnt, err_cnt}, '0);
    rgmii_rxd = '0;
    rgmii_rx_ctl = 1'b0;
    exp_q.delete();
    @(negedge rgmii_rxc);
    #1;
    rst_n = 1'b1;
    gidle(8);
    chk("reset_no_end", ends, 4);
    chk("reset_cnts", {frame_cnt, err_cnt}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
